// File: rtl/adc_frame_reader.sv
// Parallel-bus ADC frame controller: writes the two config words after power-up, then on each
// sample tick runs CONVST -> BUSY handshake -> NUM_CH reads, streaming samples out via valid/ready.
module adc_frame_reader #(
  parameter int NUM_CH      = 8,
  parameter int SAMPLE_DIV  = 1000,
  parameter int PWRUP_CYC   = 16,
  parameter int CONVST_CYC  = 4,
  parameter int WR_CYC      = 3,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 3,
  parameter int GAP_CYC     = 4,
  parameter int BUSY_TO_CYC = 256
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      CLR_FLAGS,
  input  logic [15:0]               CFG_WORD0,
  input  logic [15:0]               CFG_WORD1,
  output logic [3:0]                CONVST,
  output logic                      CS_N,
  output logic                      WR_N,
  output logic                      RD_N,
  input  logic                      BUSY,
  input  logic [15:0]               DB_IN,
  output logic [15:0]               DB_OUT,
  output logic                      DB_OE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [15:0]               OUT_DATA,
  output logic [$clog2(NUM_CH)-1:0] OUT_CH,
  output logic                      OUT_LAST,
  output logic                      OVERRUN,
  output logic                      TIMEOUT
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int MAX_A  = (PWRUP_CYC > BUSY_TO_CYC) ? PWRUP_CYC : BUSY_TO_CYC;
  localparam int MAX_B  = (CONVST_CYC > WR_CYC) ? CONVST_CYC : WR_CYC;
  localparam int MAX_C  = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int MAX_D  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_E  = (MAX_C > GAP_CYC) ? MAX_C : GAP_CYC;
  localparam int MAX_CY = (MAX_D > MAX_E) ? MAX_D : MAX_E;
  localparam int CNT_W  = $clog2(MAX_CY + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PWRUP_LAST  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0]  CONVST_LAST = CNT_W'(CONVST_CYC - 1);
  localparam logic [CNT_W-1:0]  WR_LAST     = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0]  RDLO_LAST   = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0]  RDHI_LAST   = CNT_W'(RD_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  BUSY_LAST   = CNT_W'(BUSY_TO_CYC - 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
  localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]   CH_ONE      = CH_W'(1);

  localparam logic [3:0] S_PWRUP   = 4'd0;
  localparam logic [3:0] S_CFG     = 4'd1;
  localparam logic [3:0] S_IDLE    = 4'd2;
  localparam logic [3:0] S_CONV    = 4'd3;
  localparam logic [3:0] S_WAIT_HI = 4'd4;
  localparam logic [3:0] S_WAIT_LO = 4'd5;
  localparam logic [3:0] S_RD_LO   = 4'd6;
  localparam logic [3:0] S_PUSH    = 4'd7;
  localparam logic [3:0] S_RD_HI   = 4'd8;
  localparam logic [3:0] S_GAP     = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [15:0]       cfg0_q, cfg0_d, cfg1_q, cfg1_d;
  logic              busy_meta_q, busy_meta_d, busy_s_q, busy_s_d;
  logic [3:0]        convst_q, convst_d;
  logic              cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [15:0]       db_out_q, db_out_d;
  logic              db_oe_q, db_oe_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d, timeout_q, timeout_d;
  logic              tick;

  assign tick = EN && (tick_cnt_q == TICK_LAST);

  always_comb begin
    busy_meta_d = BUSY;
    busy_s_d    = busy_meta_q;
    if (!EN || tick) tick_cnt_d = '0;
    else             tick_cnt_d = tick_cnt_q + TICK_ONE;

    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    ch_d        = ch_q;
    cfg0_d      = cfg0_q;
    cfg1_d      = cfg1_q;
    db_out_d    = db_out_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;

    // Clear first so a same-cycle set wins.
    if (CLR_FLAGS) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (tick && (state_q != S_IDLE) && (state_q != S_PWRUP) && (state_q != S_CFG))
      overrun_d = 1'b1;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d  = S_CFG;
          cnt_d    = '0;
          phase_d  = 2'd0;
          cfg0_d   = CFG_WORD0;
          cfg1_d   = CFG_WORD1;
          db_out_d = CFG_WORD0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // phase: 0 = word0 WR low, 1 = word0 WR high, 2 = word1 WR low, 3 = word1 WR high
      S_CFG: begin
        if (cnt_q == WR_LAST) begin
          cnt_d = '0;
          if (phase_q == 2'd3) begin
            state_d  = S_IDLE;
            db_out_d = '0;
          end else begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd1) db_out_d = cfg1_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_IDLE: begin
        if (tick) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end
      end
      S_CONV: begin
        if (cnt_q == CONVST_LAST) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_HI: begin
        if (busy_s_q) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == BUSY_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LO: begin
        if (!busy_s_q) begin
          state_d = S_RD_LO;
          cnt_d   = '0;
          ch_d    = '0;
        end else if (cnt_q == BUSY_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // DB is sampled on the last RD_N-low cycle so the ADC has the full low width to settle.
      S_RD_LO: begin
        if (cnt_q == RDLO_LAST) begin
          state_d     = S_PUSH;
          cnt_d       = '0;
          out_data_d  = DB_IN;
          out_ch_d    = ch_q;
          out_last_d  = (ch_q == CH_LAST);
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PUSH: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          if (out_last_q) begin
            state_d = S_GAP;
          end else begin
            state_d = S_RD_HI;
            ch_d    = ch_q + CH_ONE;
          end
        end
      end
      S_RD_HI: begin
        if (cnt_q == RDHI_LAST) begin
          state_d = S_RD_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase

    // Bus strobes are decoded from the next state so they leave the chip straight from flops.
    cs_n_d   = !((state_d == S_CFG) || (state_d == S_RD_LO) ||
                 (state_d == S_PUSH) || (state_d == S_RD_HI));
    wr_n_d   = !((state_d == S_CFG) && !phase_d[0]);
    rd_n_d   = (state_d != S_RD_LO);
    db_oe_d  = (state_d == S_CFG);
    convst_d = (state_d == S_CONV) ? 4'hF : 4'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      tick_cnt_q  <= '0;
      phase_q     <= 2'd0;
      ch_q        <= '0;
      cfg0_q      <= '0;
      cfg1_q      <= '0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      convst_q    <= 4'h0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      db_out_q    <= '0;
      db_oe_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      ch_q        <= ch_d;
      cfg0_q      <= cfg0_d;
      cfg1_q      <= cfg1_d;
      busy_meta_q <= busy_meta_d;
      busy_s_q    <= busy_s_d;
      convst_q    <= convst_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign CONVST    = convst_q;
  assign CS_N      = cs_n_q;
  assign WR_N      = wr_n_q;
  assign RD_N      = rd_n_q;
  assign DB_OUT    = db_out_q;
  assign DB_OE     = db_oe_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_LAST  = out_last_q;
  assign OVERRUN   = overrun_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: behavioural ADC (BUSY pulse, DB = 0x1000 + read index) and a
// queue of expected samples compared as beats are accepted downstream.
module tb_adc_frame_reader;
  localparam int NUM_CH      = 8;
  localparam int SAMPLE_DIV  = 40;
  localparam int BUSY_TO_CYC = 256;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        EN = 1'b0;
  logic        CLR_FLAGS = 1'b0;
  logic [15:0] CFG_WORD0 = 16'h8054;
  logic [15:0] CFG_WORD1 = 16'h03FF;
  logic [3:0]  CONVST;
  logic        CS_N, WR_N, RD_N;
  logic        BUSY = 1'b0;
  logic [15:0] DB_IN = 16'h1000;
  logic [15:0] DB_OUT;
  logic        DB_OE, OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] OUT_DATA;
  logic [2:0]  OUT_CH;
  logic        OUT_LAST, OVERRUN, TIMEOUT;

  int checks = 0;
  int passed = 0;
  logic [19:0] exp_q[$];

  logic       busy_en = 1'b1;
  int         bcnt = 0;
  int         adc_ch = 0;
  int         rd_pulses = 0;
  logic [3:0] prev_convst = 4'h0;
  logic       prev_rd = 1'b1;

  adc_frame_reader #(.NUM_CH(NUM_CH), .SAMPLE_DIV(SAMPLE_DIV), .BUSY_TO_CYC(BUSY_TO_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR_FLAGS(CLR_FLAGS),
    .CFG_WORD0(CFG_WORD0), .CFG_WORD1(CFG_WORD1),
    .CONVST(CONVST), .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N),
    .BUSY(BUSY), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_CH(OUT_CH), .OUT_LAST(OUT_LAST), .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // ADC model: BUSY high for 20 cycles starting 2 cycles after CONVST falls; DB advances per read.
  initial forever begin
    @(negedge CLK);
    if (busy_en && prev_convst != 4'h0 && CONVST == 4'h0) bcnt = 1;
    else if (bcnt != 0) begin
      bcnt++;
      if (bcnt > 22) bcnt = 0;
    end
    BUSY = (bcnt >= 3 && bcnt <= 22);
    if (CS_N) adc_ch = 0;
    else if (!prev_rd && RD_N) adc_ch++;
    if (prev_rd && !RD_N) rd_pulses++;
    DB_IN = 16'h1000 + 16'(adc_ch);
    prev_convst = CONVST;
    prev_rd = RD_N;
  end

  task automatic push_frame;
    for (int c = 0; c < NUM_CH; c++)
      exp_q.push_back({16'h1000 + 16'(c), 3'(c), (c == NUM_CH - 1)});
  endtask

  task automatic wait_convst(output int n);
    n = 0;
    while (CONVST == 4'h0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset;
    logic [46:0] obs;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    obs = {CONVST, CS_N, WR_N, RD_N, DB_OE, DB_OUT, OUT_VALID, OUT_DATA, OUT_CH, OUT_LAST,
           OVERRUN, TIMEOUT};
    checks++;
    if (obs !== {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values got %h want %h", obs,
               {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_config;
    logic [2:0] exp_pins;
    logic [15:0] exp_db;
    int wr_falls;
    logic last_wr;
    wr_falls = 0;
    last_wr = 1'b1;
    RST_N = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge CLK);
      exp_pins[2] = !(k >= 16 && k < 28);
      exp_pins[1] = !exp_pins[2];
      exp_pins[0] = !((k >= 16 && k < 19) || (k >= 22 && k < 25));
      exp_db = (k < 22) ? 16'h8054 : 16'h03FF;
      checks++;
      if ({CS_N, DB_OE, WR_N} !== exp_pins)
        $display("FAIL cfg_pins cycle %0d got %b want %b", k, {CS_N, DB_OE, WR_N}, exp_pins);
      else passed++;
      if (exp_pins[1]) begin
        checks++;
        if (DB_OUT !== exp_db) $display("FAIL cfg_db cycle %0d got %h want %h", k, DB_OUT, exp_db);
        else passed++;
      end
      if (last_wr && !WR_N) wr_falls++;
      last_wr = WR_N;
    end
    checks++;
    if (wr_falls != 2) $display("FAIL cfg_wr_pulses got %0d want 2", wr_falls);
    else passed++;
  endtask

  task automatic test_frame;
    int n, beats, p0, stray;
    logic [19:0] e;
    push_frame();
    OUT_READY = 1'b1;
    p0 = rd_pulses;
    @(negedge CLK);
    EN = 1'b1;
    wait_convst(n);
    EN = 1'b0;
    checks++;
    if (n != SAMPLE_DIV) $display("FAIL tick_to_convst got %0d want %0d", n, SAMPLE_DIV);
    else passed++;
    beats = 0;
    n = 0;
    while (beats < NUM_CH && n < 1000) begin
      @(negedge CLK);
      n++;
      if (OUT_VALID) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL frame_beat extra beat got %h", OUT_DATA);
        else begin
          e = exp_q.pop_front();
          if ({OUT_DATA, OUT_CH, OUT_LAST} !== e)
            $display("FAIL frame_beat %0d got %h want %h", beats, {OUT_DATA, OUT_CH, OUT_LAST}, e);
          else passed++;
        end
        beats++;
      end
    end
    checks++;
    if (beats != NUM_CH) $display("FAIL frame_beats got %0d want %0d", beats, NUM_CH);
    else passed++;
    stray = 0;
    repeat (150) begin
      @(negedge CLK);
      if (CONVST != 4'h0 || OUT_VALID) stray++;
    end
    checks++;
    if (rd_pulses - p0 != NUM_CH) $display("FAIL rd_pulses got %0d want %0d", rd_pulses - p0, NUM_CH);
    else passed++;
    checks++;
    if (stray != 0) $display("FAIL en_low_no_new_conv got %0d active cycles want 0", stray);
    else passed++;
  endtask

  task automatic test_backpressure;
    int n, beats, stall;
    logic [19:0] e;
    push_frame();
    @(negedge CLK);
    EN = 1'b1;
    wait_convst(n);
    EN = 1'b0;
    beats = 0;
    stall = 0;
    n = 0;
    while (beats < NUM_CH && n < 1000) begin
      @(negedge CLK);
      n++;
      if (OUT_VALID) begin
        if (beats == 3 && stall < 10) begin
          OUT_READY = 1'b0;
          stall++;
          checks++;
          if ({OUT_DATA, OUT_CH, RD_N} !== {16'h1003, 3'd3, 1'b1})
            $display("FAIL stall_hold cycle %0d got %h want %h", stall, {OUT_DATA, OUT_CH, RD_N},
                     {16'h1003, 3'd3, 1'b1});
          else passed++;
        end else begin
          OUT_READY = 1'b1;
          checks++;
          if (exp_q.size() == 0) $display("FAIL bp_beat extra beat got %h", OUT_DATA);
          else begin
            e = exp_q.pop_front();
            if ({OUT_DATA, OUT_CH, OUT_LAST} !== e)
              $display("FAIL bp_beat %0d got %h want %h", beats, {OUT_DATA, OUT_CH, OUT_LAST}, e);
            else passed++;
          end
          beats++;
        end
      end else if (beats == 3 && stall > 0 && stall < 10) begin
        checks++;
        $display("FAIL stall_valid_dropped got 0 want 1");
      end
    end
    OUT_READY = 1'b1;
    checks++;
    if (beats != NUM_CH || stall != 10)
      $display("FAIL bp_counts got beats %0d stall %0d want %0d 10", beats, stall, NUM_CH);
    else passed++;
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_timeout;
    int n, cs_low, beats;
    logic [19:0] e;
    busy_en = 1'b0;
    @(negedge CLK);
    EN = 1'b1;
    wait_convst(n);
    EN = 1'b0;
    while (CONVST != 4'h0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    n = 0;
    cs_low = 0;
    while (!TIMEOUT && n < 400) begin
      @(negedge CLK);
      n++;
      if (!CS_N || OUT_VALID) cs_low++;
    end
    checks++;
    if (n != BUSY_TO_CYC) $display("FAIL timeout_latency got %0d want %0d", n, BUSY_TO_CYC);
    else passed++;
    checks++;
    if (cs_low != 0) $display("FAIL timeout_cs_n got %0d low cycles want 0", cs_low);
    else passed++;
    busy_en = 1'b1;
    push_frame();
    EN = 1'b1;
    wait_convst(n);
    EN = 1'b0;
    checks++;
    if (CONVST !== 4'hF) $display("FAIL timeout_retry got %h want f", CONVST);
    else passed++;
    beats = 0;
    n = 0;
    while (beats < NUM_CH && n < 1000) begin
      @(negedge CLK);
      n++;
      if (OUT_VALID) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL retry_beat extra beat got %h", OUT_DATA);
        else begin
          e = exp_q.pop_front();
          if ({OUT_DATA, OUT_CH, OUT_LAST} !== e)
            $display("FAIL retry_beat %0d got %h want %h", beats, {OUT_DATA, OUT_CH, OUT_LAST}, e);
          else passed++;
        end
        beats++;
      end
    end
    repeat (20) @(negedge CLK);
    CLR_FLAGS = 1'b1;
    @(negedge CLK);
    CLR_FLAGS = 1'b0;
    checks++;
    if (TIMEOUT !== 1'b0) $display("FAIL timeout_clear got %b want 0", TIMEOUT);
    else passed++;
  endtask

  task automatic test_overrun;
    OUT_READY = 1'b1;
    @(negedge CLK);
    EN = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      @(negedge CLK);
      if (k == 79) begin
        checks++;
        if (OVERRUN !== 1'b0) $display("FAIL overrun_before_tick got %b want 0", OVERRUN);
        else passed++;
      end
      if (k == 80) begin
        checks++;
        if (OVERRUN !== 1'b1) $display("FAIL overrun_set got %b want 1", OVERRUN);
        else passed++;
      end
      if (k == 199) CLR_FLAGS = 1'b1;
      if (k == 200) begin
        CLR_FLAGS = 1'b0;
        checks++;
        if (OVERRUN !== 1'b1) $display("FAIL overrun_set_beats_clear got %b want 1", OVERRUN);
        else passed++;
      end
      if (k == 205) CLR_FLAGS = 1'b1;
      if (k == 206) begin
        CLR_FLAGS = 1'b0;
        EN = 1'b0;
        checks++;
        if (OVERRUN !== 1'b0) $display("FAIL overrun_clear got %b want 0", OVERRUN);
        else passed++;
      end
    end
    repeat (120) @(negedge CLK);
  endtask

  task automatic test_reset_midframe;
    int n;
    OUT_READY = 1'b1;
    @(negedge CLK);
    EN = 1'b1;
    wait_convst(n);
    EN = 1'b0;
    n = 0;
    while (!(OUT_VALID && OUT_CH == 3'd4) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    while (RD_N && n < 520) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    checks++;
    if (n >= 520) $display("FAIL midframe_reach got %0d cycles want ch5 rd_lo", n);
    else passed++;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({CS_N, RD_N, OUT_VALID, WR_N, CONVST} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'h0})
      $display("FAIL async_reset got %b want %b", {CS_N, RD_N, OUT_VALID, WR_N, CONVST},
               {1'b1, 1'b1, 1'b0, 1'b1, 4'h0});
    else passed++;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    n = 0;
    while (CS_N && n < 60) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if ({n, WR_N, DB_OE, DB_OUT} !== {32'd16, 1'b0, 1'b1, 16'h8054})
      $display("FAIL recfg_word0 got n=%0d wr=%b oe=%b db=%h want 16 0 1 8054", n, WR_N, DB_OE, DB_OUT);
    else passed++;
    repeat (6) @(negedge CLK);
    checks++;
    if ({WR_N, DB_OUT} !== {1'b0, 16'h03FF})
      $display("FAIL recfg_word1 got wr=%b db=%h want 0 03ff", WR_N, DB_OUT);
    else passed++;
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    #1;
    test_reset();
    test_config();
    test_frame();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
